alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 10, cycles SW is stable before a strobe rises (legal range 1..65535).
REQ-002 Parameter PULSE_CYC, default 10, cycles a strobe is held high (legal range 1..65535).
REQ-003 Parameter HOLD_CYC, default 10, cycles SW is held after a strobe falls (legal range 1..65535).
REQ-004 Parameter SETTLE_CYC, default 100, cycles waited after the clk_F phase before completion (legal range 1..65535).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_ready  output  1  sequencer idle and able to accept a command.
REQ-010 cmd_a  input  32  operand A.
REQ-011 cmd_b  input  32  operand B.
REQ-012 cmd_op  input  4  ALU function code.
REQ-013 SW  output  32  operand/function bus to the ALU top.
REQ-014 clk_A / clk_B / clk_F  output  1 each  load strobes for A, B and the function register.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 States: IDLE, then phases A, B and F, each with the steps SETUP, PULSE and HOLD, then SETTLE, then back to IDLE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with rst low; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-019 On accept, cmd_a, cmd_b and cmd_op SHALL be captured internally; later input changes have no effect until the next accept.
REQ-020 The cycle after accept SHALL enter A_SETUP with SW=cmd_a captured value.
REQ-021 Each SETUP step lasts exactly SETUP_CYC cycles, PULSE exactly PULSE_CYC, HOLD exactly HOLD_CYC, and SETTLE exactly SETTLE_CYC; one 16-bit down-counter is reloaded on each step entry.
REQ-022 The strobe of the current phase SHALL be 1 only during its PULSE step; at most one strobe is high in any cycle.
REQ-023 SW value by phase: A phase = captured A; B phase = captured B; F phase and SETTLE = {28'b0, captured op}.
REQ-024 SW SHALL be constant throughout each phase's SETUP, PULSE and HOLD steps; SW changes only on phase entry.
REQ-025 In IDLE, SW SHALL hold its last driven value.
REQ-026 SW, the strobes, busy and done SHALL be registered outputs with no combinational path from any input.
REQ-027 busy SHALL be 1 from the cycle after accept through the last SETTLE cycle.
REQ-028 done SHALL be 1 for exactly the first IDLE cycle after SETTLE.
REQ-029 Latency: done SHALL assert 3*(SETUP_CYC+PULSE_CYC+HOLD_CYC)+SETTLE_CYC+1 cycles after the accept edge; this is 191 cycles with the defaults.
REQ-030 Back-to-back commands: a command offered during the done cycle SHALL be accepted in that cycle, with no idle gap.
REQ-031 cmd_valid asserted while busy SHALL be ignored; it does not queue a command and does not change any output.

Reset
REQ-032 While rst=1, regardless of clk: state=IDLE, SW=0, clk_A=clk_B=clk_F=0, busy=0, done=0, cmd_ready=0, captured registers=0.
REQ-033 Reset asserted mid-operation, including mid-pulse, SHALL drop the active strobe immediately and abandon the command, with no done pulse.
REQ-034 After rst deasserts, cmd_ready SHALL be 1 from the first clock edge in IDLE.

Verification
REQ-035 Reset: pulse rst between clock edges -> all outputs 0 immediately; after release, cmd_ready=1 and SW=0.
REQ-036 Overflow add: A=FFFFFFFF, B=FFFFFFFF, op=0 -> clk_A high cycles 11-20 after accept with SW=FFFFFFFF; clk_B high cycles 41-50 with SW=FFFFFFFF; clk_F high cycles 71-80 with SW=00000000; done at cycle 191.
REQ-037 Shift: A=1, B=2, op=1 -> SW=00000001 during A, 00000002 during B, 00000001 during F; each strobe is 10 cycles wide and SW is stable 10 cycles on either side of it.
REQ-038 Signed compare back-to-back: A=A0000001, B=1, op=2, then A=2, B=1, op=2 held valid -> second command accepted in the first command's done cycle; clk_A of the second command rises 11 cycles later.
REQ-039 Busy interference: toggle cmd_valid and change cmd_a/cmd_b/cmd_op every cycle while busy -> SW sequence, strobe timing and done cycle identical to the undisturbed run.
REQ-040 Reset mid-pulse: assert rst during clk_B high -> clk_B=0 and SW=0 without waiting for a clock edge, no done pulse; a new command then completes normally in 191 cycles.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Command and ALU-strobe bus of the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic [31:0] SW;
  logic        clk_A;
  logic        clk_B;
  logic        clk_F;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready, SW, clk_A, clk_B, clk_F, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready, SW, clk_A, clk_B, clk_F, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Drives operand A, operand B and function code onto SW with
//               setup/pulse/hold strobe timing, then waits a settle period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
  parameter int SETUP_CYC  = 10,
  parameter int PULSE_CYC  = 10,
  parameter int HOLD_CYC   = 10,
  parameter int SETTLE_CYC = 100
) (
  input  wire logic           clk,
  input  wire logic           rst,
  alu_op_sequencer_if.slave   bus
);

  // Counter reload values: a step of N cycles counts N-1 down to 0.
  localparam logic [15:0] c_setup_ld  = 16'(SETUP_CYC - 1);
  localparam logic [15:0] c_pulse_ld  = 16'(PULSE_CYC - 1);
  localparam logic [15:0] c_hold_ld   = 16'(HOLD_CYC - 1);
  localparam logic [15:0] c_settle_ld = 16'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_A_SETUP = 4'd1,
    S_A_PULSE = 4'd2,
    S_A_HOLD  = 4'd3,
    S_B_SETUP = 4'd4,
    S_B_PULSE = 4'd5,
    S_B_HOLD  = 4'd6,
    S_F_SETUP = 4'd7,
    S_F_PULSE = 4'd8,
    S_F_HOLD  = 4'd9,
    S_SETTLE  = 4'd10
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [31:0] r_sw;
  logic        r_clk_a;
  logic        r_clk_b;
  logic        r_clk_f;
  logic        r_busy;
  logic        r_done;
  logic        w_step_end;

  assign w_step_end = (r_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 4'd0;
      r_sw    <= 32'd0;
      r_clk_a <= 1'b0;
      r_clk_b <= 1'b0;
      r_clk_f <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!w_step_end) begin
        r_cnt <= r_cnt - 16'd1;
      end
      // Every step transition below reloads the counter for the step it enters.
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_a     <= bus.cmd_a;
            r_b     <= bus.cmd_b;
            r_op    <= bus.cmd_op;
            r_sw    <= bus.cmd_a;
            r_busy  <= 1'b1;
            r_cnt   <= c_setup_ld;
            r_state <= S_A_SETUP;
          end
        end
        S_A_SETUP: if (w_step_end) begin
          r_clk_a <= 1'b1;
          r_cnt   <= c_pulse_ld;
          r_state <= S_A_PULSE;
        end
        S_A_PULSE: if (w_step_end) begin
          r_clk_a <= 1'b0;
          r_cnt   <= c_hold_ld;
          r_state <= S_A_HOLD;
        end
        S_A_HOLD: if (w_step_end) begin
          r_sw    <= r_b;
          r_cnt   <= c_setup_ld;
          r_state <= S_B_SETUP;
        end
        S_B_SETUP: if (w_step_end) begin
          r_clk_b <= 1'b1;
          r_cnt   <= c_pulse_ld;
          r_state <= S_B_PULSE;
        end
        S_B_PULSE: if (w_step_end) begin
          r_clk_b <= 1'b0;
          r_cnt   <= c_hold_ld;
          r_state <= S_B_HOLD;
        end
        S_B_HOLD: if (w_step_end) begin
          r_sw    <= {28'd0, r_op};
          r_cnt   <= c_setup_ld;
          r_state <= S_F_SETUP;
        end
        S_F_SETUP: if (w_step_end) begin
          r_clk_f <= 1'b1;
          r_cnt   <= c_pulse_ld;
          r_state <= S_F_PULSE;
        end
        S_F_PULSE: if (w_step_end) begin
          r_clk_f <= 1'b0;
          r_cnt   <= c_hold_ld;
          r_state <= S_F_HOLD;
        end
        S_F_HOLD: if (w_step_end) begin
          r_cnt   <= c_settle_ld;
          r_state <= S_SETTLE;
        end
        S_SETTLE: if (w_step_end) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= 16'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is the only unregistered output; it must drop with rst at once.
  assign bus.cmd_ready = (r_state == S_IDLE) && !rst;
  assign bus.SW        = r_sw;
  assign bus.clk_A     = r_clk_a;
  assign bus.clk_B     = r_clk_b;
  assign bus.clk_F     = r_clk_f;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed and randomized self-checking bench for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  localparam int SETUP  = 10;
  localparam int PULSE  = 10;
  localparam int HOLD   = 10;
  localparam int SETTLE = 100;
  localparam int PHASE  = SETUP + PULSE + HOLD;
  localparam int LAT    = 3 * PHASE + SETTLE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .SETUP_CYC (SETUP),
    .PULSE_CYC (PULSE),
    .HOLD_CYC  (HOLD),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Observed bundle: {ready, busy, done, clk_A, clk_B, clk_F, SW}
  function automatic logic [37:0] obs();
    return {bus.cmd_ready, bus.busy, bus.done, bus.clk_A, bus.clk_B, bus.clk_F, bus.SW};
  endfunction

  function automatic logic [37:0] idle_exp(input logic [31:0] sw);
    return {1'b1, 5'b00000, sw};
  endfunction

  // Expected bundle k cycles after the accept edge, from the phase timing rules.
  function automatic logic [37:0] model(input int k, input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [31:0] sw;
    logic [2:0]  strobes;
    int          ph;
    int          w;
    strobes = 3'b000;
    if (k <= 3 * PHASE) begin
      ph = (k - 1) / PHASE;
      w  = (k - 1) % PHASE;
      sw = (ph == 0) ? a : (ph == 1) ? b : {28'd0, op};
      if (w >= SETUP && w < SETUP + PULSE) strobes = 3'b100 >> ph;
      return {1'b0, 1'b1, 1'b0, strobes, sw};
    end else if (k < LAT) begin
      return {1'b0, 1'b1, 1'b0, 3'b000, {28'd0, op}};
    end
    return {1'b1, 1'b0, 1'b1, 3'b000, {28'd0, op}};
  endfunction

  task automatic chk(input string tag, input int k, input logic [37:0] o, input logic [37:0] e);
    checks++;
    assert (o === e)
    else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    end
  endtask

  // Called at a falling edge; the command is accepted on the next rising edge.
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    chk("ready_before_accept", 0, {37'd0, bus.cmd_ready}, 38'd1);
  endtask

  // Follows one accepted command cycle by cycle; returns early after cycle stop_at.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input bit disturb, input int stop_at);
    @(posedge clk);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk(disturb ? "cmd_disturbed" : "cmd", k, obs(), model(k, a, b, op));
      if (k == stop_at) return;
      if (k < LAT) begin
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        bus.cmd_op    = 4'($urandom_range(0, 15));
        bus.cmd_valid = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [3:0]  rop;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.cmd_op    = 4'd0;

    // Reset held from time zero: everything low, including ready.
    #2;
    chk("reset_outputs", 0, obs(), 38'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_reset", 0, obs(), idle_exp(32'd0));
    @(negedge clk);
    chk("idle", 0, obs(), idle_exp(32'd0));

    // Overflow add operands.
    offer(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0);
    run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, 1'b0, 0);

    // SW holds the function code while idle.
    @(negedge clk);
    chk("idle_hold_sw", 0, obs(), idle_exp(32'd0));

    // Shift operands.
    offer(32'd1, 32'd2, 4'd1);
    run_cmd(32'd1, 32'd2, 4'd1, 1'b0, 0);
    @(negedge clk);
    chk("idle_hold_sw", 0, obs(), idle_exp(32'd1));

    // Reset pulse between clock edges clears the held SW immediately.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_pulse", 0, obs(), 38'd0);
    #2 rst = 1'b0;
    #1 chk("after_reset_pulse", 0, obs(), idle_exp(32'd0));

    // Back-to-back signed compares: second offered in the done cycle.
    @(negedge clk);
    offer(32'hA000_0001, 32'd1, 4'd2);
    run_cmd(32'hA000_0001, 32'd1, 4'd2, 1'b0, 0);
    offer(32'd2, 32'd1, 4'd2);
    run_cmd(32'd2, 32'd1, 4'd2, 1'b0, 0);

    // Inputs churn every cycle while busy.
    @(negedge clk);
    offer(32'h1234_5678, 32'h9ABC_DEF0, 4'd7);
    run_cmd(32'h1234_5678, 32'h9ABC_DEF0, 4'd7, 1'b1, 0);

    // Random commands, alternately disturbed, chained back-to-back.
    for (int i = 0; i < 3; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 4'($urandom_range(0, 15));
      offer(ra, rb, rop);
      run_cmd(ra, rb, rop, 1'(i % 2), 0);
    end

    // Reset in the middle of the B strobe.
    @(negedge clk);
    offer(32'hCAFE_F00D, 32'h0BAD_BEEF, 4'd5);
    run_cmd(32'hCAFE_F00D, 32'h0BAD_BEEF, 4'd5, 1'b0, 45);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1 chk("reset_mid_pulse", 45, obs(), 38'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", k, obs(), idle_exp(32'd0));
    end

    // A fresh command completes with normal latency.
    offer(32'h0000_00FF, 32'hFF00_0000, 4'd9);
    run_cmd(32'h0000_00FF, 32'hFF00_0000, 4'd9, 1'b0, 0);
    @(negedge clk);
    chk("final_idle", 0, obs(), idle_exp(32'd9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
